grill_scheduler: RTL

Central cook-sequencing controller for the grill. It owns NUM_SLOTS steak slots, each holding a 3-bit doneness level, and advances every occupied slot one level per cook tick using a staggered one-slot-per-cycle scan. It also takes place and serve requests from the player input logic over a single valid/ready port. Its outputs drive the per-slot display and the scoring logic.

---
 rtl/grill_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/grill_scheduler.sv
// Grill cook sequencer: NUM_SLOTS doneness levels advanced one slot per cycle on each cook tick.
// Define GRILL_AUTOCLEAR_EN to clear burnt slots during a scan and expose the burn_evt pulse.
module grill_scheduler #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2,
  parameter int TICK_DIV  = 50000000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pause,
  input  logic                   req_valid,
  input  logic                   req_serve,
  input  logic [SLOT_W-1:0]      req_slot,
  output logic                   req_ready,
  output logic [3*NUM_SLOTS-1:0] doneness,
  output logic                   served_valid,
  output logic [SLOT_W-1:0]      served_slot,
  output logic [2:0]             served_level,
  output logic                   req_err,
`ifdef GRILL_AUTOCLEAR_EN
  output logic                   burn_evt,
`endif
  output logic                   burnt_alarm
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SLOT_W-1:0] LAST_IDX  = SLOT_W'(NUM_SLOTS - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_reg, state_next;
  logic [SLOT_W-1:0] idx_reg, idx_next;
  logic              pending_reg, pending_next;
  logic [PW-1:0]     presc_reg;
  logic              tick, accept;
  logic [2:0]        sel_lvl;
  logic              slot_ok, any_burnt;
  logic              served_valid_reg, req_err_reg, burnt_alarm_reg;
  logic [SLOT_W-1:0] served_slot_reg;
  logic [2:0]        served_level_reg;

  assign tick   = !pause && (presc_reg == PRESC_MAX);
  assign accept = req_valid && (state_reg == IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_reg <= '0;
    end else if (!pause) begin
      presc_reg <= tick ? '0 : presc_reg + PW'(1);
    end
  end

  always_comb begin
    state_next   = state_reg;
    idx_next     = idx_reg;
    pending_next = pending_reg | tick;
    req_ready    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (pending_reg || tick) begin
          state_next   = SCAN;
          idx_next     = '0;
          pending_next = 1'b0;
        end
      end
      SCAN: begin
        if (idx_reg == LAST_IDX) begin
          idx_next = '0;
          // A tick that landed mid-scan chains straight into another scan.
          if (pending_reg || tick) begin
            pending_next = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          idx_next = idx_reg + SLOT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      idx_reg     <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      idx_reg     <= idx_next;
      pending_reg <= pending_next;
    end
  end

  for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
    logic [2:0] lvl_reg;
    always_ff @(posedge clock) begin
      if (reset) begin
        lvl_reg <= '0;
      end else if (state_reg == SCAN && idx_reg == SLOT_W'(gi)) begin
        if (lvl_reg != 3'd0 && lvl_reg != 3'd7) begin
          lvl_reg <= lvl_reg + 3'd1;
`ifdef GRILL_AUTOCLEAR_EN
        end else if (lvl_reg == 3'd7) begin
          lvl_reg <= '0;
`endif
        end
      end else if (accept && req_slot == SLOT_W'(gi)) begin
        // Serving an empty slot writes 0 over 0, so no extra guard is needed.
        if (req_serve) begin
          lvl_reg <= '0;
        end else if (lvl_reg == 3'd0) begin
          lvl_reg <= 3'd1;
        end
      end
    end
    assign doneness[3*gi +: 3] = lvl_reg;
  end

  always_comb begin
    sel_lvl   = '0;
    slot_ok   = 1'b0;
    any_burnt = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (req_slot == SLOT_W'(i)) begin
        slot_ok = 1'b1;
        sel_lvl = doneness[3*i +: 3];
      end
      if (doneness[3*i +: 3] == 3'd7) begin
        any_burnt = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      served_valid_reg <= 1'b0;
      served_slot_reg  <= '0;
      served_level_reg <= '0;
      req_err_reg      <= 1'b0;
      burnt_alarm_reg  <= 1'b0;
    end else begin
      served_valid_reg <= accept && req_serve && slot_ok && (sel_lvl != 3'd0);
      req_err_reg      <= accept && (!slot_ok || (req_serve ? (sel_lvl == 3'd0) : (sel_lvl != 3'd0)));
      burnt_alarm_reg  <= any_burnt;
      if (accept && req_serve && slot_ok && sel_lvl != 3'd0) begin
        served_slot_reg  <= req_slot;
        served_level_reg <= sel_lvl;
      end
    end
  end

  assign served_valid = served_valid_reg;
  assign served_slot  = served_slot_reg;
  assign served_level = served_level_reg;
  assign req_err      = req_err_reg;
  assign burnt_alarm  = burnt_alarm_reg;

`ifdef GRILL_AUTOCLEAR_EN
  logic [2:0] scan_lvl;
  logic       burn_evt_reg;

  always_comb begin
    scan_lvl = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (idx_reg == SLOT_W'(i)) begin
        scan_lvl = doneness[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      burn_evt_reg <= 1'b0;
    end else begin
      burn_evt_reg <= (state_reg == SCAN) && (scan_lvl == 3'd7);
    end
  end

  assign burn_evt = burn_evt_reg;
`endif

endmodule
